uart_lb_ctrl: RTL
=================

Name: uart_lb_ctrl

Overview:
Command sequencer between the host UART byte stream and the qubic local register bus (lb_*).
- Frames the incoming byte stream into 64-bit commands: {cmd[7:0], addr[23:0], data[31:0]}, MSB byte first.
- Locks onto the stream using a sync preamble.
- Issues single-cycle write and read strobes on the local bus.
- Serializes read responses back to the host through the uart transmitter handshake.
- Sits between the uart instance (clocked by uartclk) and the register file.

Parameters:
AWIDTH, 24, local bus address width (command addr field)
DWIDTH, 32, local bus data width (command data field)
RD_TIMEOUT, 255, max clk cycles from lb_rstrb to lb_rvalid before a timeout response is sent
ERRW, 16, width of the saturating error counter

Ports:
clk  in  1  uartclk domain; all logic rising-edge
rst  in  1  synchronous, active-high reset
rxdata  in  8  received byte
rxvalid  in  1  one-cycle strobe, rxdata valid
txdata  out  8  byte to transmit
txstart  out  1  one-cycle transmit request
txready  in  1  uart transmitter idle
lb_addr  out  AWIDTH  bus address
lb_wdata  out  DWIDTH  bus write data
lb_wstrb  out  1  one-cycle write strobe
lb_rstrb  out  1  one-cycle read strobe
lb_rdata  in  DWIDTH  read data, sampled when lb_rvalid=1
lb_rvalid  in  1  read data valid
synced  out  1  framer locked
err_cnt  out  ERRW  saturating count of dropped or invalid commands and timeouts

Behaviour:
Reset:
- Reset is synchronous and active-high. One clock; all logic on the rising edge of clk.
- rst=1 forces state HUNT. All outputs become 0 on the next edge: txstart, lb_wstrb, lb_rstrb, synced, err_cnt, txdata, lb_addr, lb_wdata.
- Mid-operation reset aborts any pending read or partial response. No further txstart is issued.

Framer:
- ffcnt is a 4-bit saturating count of consecutive 0xFF rx bytes; any non-FF byte clears it.
- Sync event: rx byte 0x00 with ffcnt==15, i.e. words FFFFFFFF_FFFFFFFF then FFFFFFFF_FFFFFF00.
- On sync event: synced<=1, byte index<=0. This applies in any state and re-aligns without raising an error.
- While synced, each rxvalid shifts the byte into a 64-bit word. The 8th byte completes the word.
- A completed word equal to either sync word is discarded silently.

Dispatch (cycle after the word completes):
- cmd 0x01 WRITE: lb_addr, lb_wdata <= fields; lb_wstrb=1 for exactly 1 cycle. Writes are accepted in every synced state, including during TX.
- cmd 0x00 READ, FSM in IDLE: lb_addr <= addr; lb_rstrb=1 for 1 cycle; go to RD_WAIT.
- READ while in RD_WAIT or TX: command dropped, err_cnt+1.
- Any other cmd: dropped, err_cnt+1.
- err_cnt saturates at all-ones.

Control FSM (states IDLE, RD_WAIT, TX):
- RD_WAIT: counts cycles.
  - lb_rvalid=1 → response = {8'h00, addr, lb_rdata}.
  - Count reaches RD_TIMEOUT → response = {8'hEE, addr, 32'hDEADBEEF}, err_cnt+1.
  - Either case → TX.
  - lb_rvalid and timeout on the same cycle: rvalid wins.
- TX: 8 bytes, MSB first.
  - txstart is pulsed only when txready=1 and guard=0. guard is set for the 2 cycles following each txstart.
  - txdata is held stable from the txstart cycle until the next txstart.
  - After the 8th byte → IDLE.
- lb_rvalid outside RD_WAIT is ignored.

Latency:
- Word-complete rxvalid → lb_wstrb/lb_rstrb: 1 cycle.
- lb_rvalid → first txstart: ≤2 cycles when txready=1.

Decomposition:
Package uart_lb_pkg holds:
- CMD_READ=8'h00, CMD_WRITE=8'h01, RESP_OK=8'h00, RESP_TMO=8'hEE
- SYNC0=64'hFFFFFFFF_FFFFFFFF, SYNC1=64'hFFFFFFFF_FFFFFF00
- TMO_DATA=32'hDEADBEEF
- state enum {IDLE, RD_WAIT, TX}

One sub-module, uart_lb_txser:
- Interface: load 64-bit word with a 1-cycle load pulse; busy out.
- Contains the txready/guard handshake, byte counter and txdata register.

Test Plan:
- Sync preamble, then 01000017_00E02281 → one lb_wstrb with lb_addr=0x000017 and lb_wdata=0x00E02281; synced=1; err_cnt=0.
- Read 00000009_00000000, lb_rvalid after 3 cycles with lb_rdata=0x12345678 → single lb_rstrb at addr 9; bytes 00 00 00 09 12 34 56 78 emitted in order, one per txready cycle.
- Write 01000015_00000000 before sync (after reset) → no lb_wstrb, synced=0; after preamble plus the same word → one strobe.
- cmd 0x05 word, then a second READ issued while the first response is in TX → both dropped; err_cnt=2; first response completes intact.
- READ with lb_rvalid never asserted → after RD_TIMEOUT cycles the response is 0xEE, addr, DE AD BE EF; err_cnt+1; FSM returns to IDLE.
- rst pulse after 3 response bytes → no further txstart; synced=0; all outputs 0; a fresh preamble plus READ works normally.

Source files
------------

// File: rtl/uart_lb_pkg.sv
// Shared constants and types for the UART local-bus command sequencer.
// Command word layout: {cmd[7:0], addr[23:0], data[31:0]}, MSB byte first.
package uart_lb_pkg;

    localparam logic [7:0]  CMD_READ  = 8'h00;
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  RESP_OK   = 8'h00;
    localparam logic [7:0]  RESP_TMO  = 8'hEE;
    localparam logic [63:0] SYNC0     = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] SYNC1     = 64'hFFFFFFFF_FFFFFF00;
    localparam logic [31:0] TMO_DATA  = 32'hDEADBEEF;
    localparam int          NBYTES    = 8;
    localparam int          GUARD_CYC = 2;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        TX
    } state_t;

    function automatic logic is_sync(input logic [63:0] w);
        return (w == SYNC0) || (w == SYNC1);
    endfunction

endpackage

// File: rtl/uart_lb_txser.sv
// Serializes a 64-bit response into UART bytes, MSB first, pacing each
// byte on txready and a short guard window after every txstart.
module uart_lb_txser
    import uart_lb_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [63:0] i_word,
    input  logic        i_txready,
    output logic [7:0]  o_txdata,
    output logic        o_txstart,
    output logic        o_busy
);

    logic [63:0] r_shift;
    logic [2:0]  r_cnt;
    logic [1:0]  r_guard;
    logic        r_busy;
    logic        w_fire;

    // The cycle carrying txstart also blocks, so the next byte is >=3 cycles later.
    assign w_fire = r_busy && i_txready && (r_guard == 2'd0) && !o_txstart;
    assign o_busy = r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_guard   <= '0;
            r_busy    <= 1'b0;
            o_txdata  <= '0;
            o_txstart <= 1'b0;
        end else begin
            o_txstart <= w_fire;
            if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
            if (i_load) begin
                r_shift <= i_word;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end else if (w_fire) begin
                o_txdata <= r_shift[63:56];
                r_shift  <= {r_shift[55:0], 8'h00};
                r_cnt    <= r_cnt + 3'd1;
                r_guard  <= 2'(GUARD_CYC);
                if (r_cnt == 3'(NBYTES - 1)) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/uart_lb_ctrl.sv
// Frames host UART bytes into 64-bit local-bus commands, issues bus
// strobes, and returns read responses through the UART transmitter.
module uart_lb_ctrl
    import uart_lb_pkg::*;
#(
    parameter int AWIDTH     = 24,
    parameter int DWIDTH     = 32,
    parameter int RD_TIMEOUT = 255,
    parameter int ERRW       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rxdata,
    input  logic              rxvalid,
    output logic [7:0]        txdata,
    output logic              txstart,
    input  logic              txready,
    output logic [AWIDTH-1:0] lb_addr,
    output logic [DWIDTH-1:0] lb_wdata,
    output logic              lb_wstrb,
    output logic              lb_rstrb,
    input  logic [DWIDTH-1:0] lb_rdata,
    input  logic              lb_rvalid,
    output logic              synced,
    output logic [ERRW-1:0]   err_cnt
);

    localparam int TW = $clog2(RD_TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_ffcnt;
    logic [2:0]        r_idx;
    logic [55:0]       r_shift;
    logic [AWIDTH-1:0] r_rd_addr;
    logic [TW-1:0]     r_tcnt;
    logic [63:0]       w_word;
    logic [63:0]       w_resp;
    logic              w_sync_ev;
    logic              w_done;
    logic              w_is_wr;
    logic              w_is_rd;
    logic              w_drop;
    logic              w_rd_go;
    logic              w_load;
    logic              w_tmo;
    logic              w_busy;
    logic [1:0]        w_inc;
    logic [ERRW:0]     w_err_sum;
    logic [ERRW-1:0]   w_err_nx;

    // A 0x00 after fifteen 0xFF bytes re-aligns the framer, whatever it was doing.
    assign w_sync_ev = rxvalid && (rxdata == 8'h00) && (r_ffcnt == 4'hF);
    assign w_word    = {r_shift, rxdata};
    assign w_done    = synced && rxvalid && !w_sync_ev
                    && (r_idx == 3'd7) && !is_sync(w_word);
    assign w_is_wr   = w_done && (w_word[63:56] == CMD_WRITE);
    assign w_is_rd   = w_done && (w_word[63:56] == CMD_READ);

    always_comb begin
        w_state_nx = r_state;
        w_rd_go    = 1'b0;
        w_load     = 1'b0;
        w_tmo      = 1'b0;
        w_resp     = '0;
        w_drop     = w_done && !w_is_wr;
        unique case (r_state)
            IDLE: begin
                if (w_is_rd) begin
                    w_rd_go    = 1'b1;
                    w_drop     = 1'b0;
                    w_state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lb_rvalid) begin
                    w_load     = 1'b1;
                    w_resp     = {RESP_OK, r_rd_addr, lb_rdata};
                    w_state_nx = TX;
                end else if (r_tcnt == TW'(RD_TIMEOUT)) begin
                    w_load     = 1'b1;
                    w_tmo      = 1'b1;
                    w_resp     = {RESP_TMO, r_rd_addr, TMO_DATA};
                    w_state_nx = TX;
                end
            end
            TX: begin
                if (!w_busy) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // A dropped command and a timeout can land on the same cycle.
    assign w_inc     = {1'b0, w_drop} + {1'b0, w_tmo};
    assign w_err_sum = {1'b0, err_cnt} + {{(ERRW-1){1'b0}}, w_inc};
    assign w_err_nx  = w_err_sum[ERRW] ? '1 : w_err_sum[ERRW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ffcnt   <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_rd_addr <= '0;
            r_tcnt    <= '0;
            synced    <= 1'b0;
            lb_addr   <= '0;
            lb_wdata  <= '0;
            lb_wstrb  <= 1'b0;
            lb_rstrb  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            if (rxvalid) begin
                r_ffcnt <= (rxdata != 8'hFF) ? 4'h0
                         : (r_ffcnt == 4'hF) ? 4'hF : r_ffcnt + 4'h1;
            end
            if (w_sync_ev) begin
                synced <= 1'b1;
                r_idx  <= '0;
            end else if (synced && rxvalid) begin
                r_shift <= w_word[55:0];
                r_idx   <= r_idx + 3'd1;
            end
            lb_wstrb <= w_is_wr;
            lb_rstrb <= w_rd_go;
            if (w_is_wr) begin
                lb_addr  <= w_word[32 +: AWIDTH];
                lb_wdata <= w_word[DWIDTH-1:0];
            end else if (w_rd_go) begin
                lb_addr   <= w_word[32 +: AWIDTH];
                r_rd_addr <= w_word[32 +: AWIDTH];
            end
            r_tcnt  <= (r_state == RD_WAIT) ? r_tcnt + 1'b1 : '0;
            err_cnt <= w_err_nx;
        end
    end

    uart_lb_txser u_txser (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_load),
        .i_word    (w_resp),
        .i_txready (txready),
        .o_txdata  (txdata),
        .o_txstart (txstart),
        .o_busy    (w_busy)
    );

endmodule
